// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA horizontal and vertical timing
// generators: standard vertical mode timings and the line-region decode.
package vga_timing_pkg;

  // Screen region a scanline (or pixel) falls in.
  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    BACK   = 2'd1,
    ACTIVE = 2'd2,
    FRONT  = 2'd3
  } region_t;

  // 640x480 @ 60 Hz vertical timing (lines).
  localparam int MODE_640X480_V_SYNC   = 2;
  localparam int MODE_640X480_V_BACK   = 33;
  localparam int MODE_640X480_V_ACTIVE = 480;
  localparam int MODE_640X480_V_FRONT  = 10;

  // 640x480 variant used by the scaled framebuffer path (shorter back porch).
  localparam int MODE_480S_V_SYNC   = 2;
  localparam int MODE_480S_V_BACK   = 29;
  localparam int MODE_480S_V_ACTIVE = 480;
  localparam int MODE_480S_V_FRONT  = 10;

  // 800x600 @ 60 Hz vertical timing (lines).
  localparam int MODE_800X600_V_SYNC   = 4;
  localparam int MODE_800X600_V_BACK   = 23;
  localparam int MODE_800X600_V_ACTIVE = 600;
  localparam int MODE_800X600_V_FRONT  = 1;

  // Map a position inside the frame to its region. Sync comes first,
  // then back porch, active, and front porch fills the rest.
  function automatic region_t line_region(input int line, input int sync,
                                           input int back, input int active);
    region_t r;
    if (line < sync)                      r = SYNC;
    else if (line < sync + back)          r = BACK;
    else if (line < sync + back + active) r = ACTIVE;
    else                                  r = FRONT;
    return r;
  endfunction

endpackage

// File: rtl/vga_vtiming_if.sv
// Signal bundle between the vertical timing generator and its consumers.
// The optional frame_cnt member exists only when VGA_VTIMING_FRAME_CNT_EN
// is defined.
//
// Handshake: there is no valid/ready pair. line_tick is a one-cycle strobe
// qualified by en; every cycle with en && line_tick counts as one line end.
// All timing outputs are registered and change on the clk edge that samples
// a qualifying tick.
interface vga_vtiming_if #(
  parameter int ROW_W = 7
);
  logic             en;
  logic             line_tick;
  logic             vsync;
  logic             v_active;
  logic [ROW_W-1:0] row;
  logic             frame_start;
  logic             last_line;
`ifdef VGA_VTIMING_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  // Timing generator side.
  modport master (
    input  en, line_tick,
    output vsync, v_active, row, frame_start, last_line
`ifdef VGA_VTIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  // Line strobe source / timing consumer side.
  modport slave (
    output en, line_tick,
    input  vsync, v_active, row, frame_start, last_line
`ifdef VGA_VTIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_row_scaler.sv
// Row prescaler: divides active scanlines by SCALE to produce the row index
// used by the pixel fetch logic. Row and prescaler both return to zero on the
// tick that ends the last active line, so row is 0 outside the active window.
module vga_row_scaler #(
  parameter int SCALE = 5,
  parameter int ROW_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,        // counted line tick (en already applied)
  input  logic             active,      // line now ending is an active line
  input  logic             last_active, // line now ending is the last active line
  output logic [ROW_W-1:0] row
);
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Next prescaler / row value on each tick that ends an active line.
  always_comb begin
    sub_cnt_d = sub_cnt_q;
    row_d     = row_q;
    if (tick && active) begin
      if (last_active) begin
        sub_cnt_d = '0;
        row_d     = '0;
      end else if (sub_cnt_q == SUB_W'(SCALE - 1)) begin
        sub_cnt_d = '0;
        row_d     = row_q + ROW_W'(1);
      end else begin
        sub_cnt_d = sub_cnt_q + SUB_W'(1);
      end
    end
  end

  // Prescaler and row registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_cnt_q <= '0;
      row_q     <= '0;
    end else begin
      sub_cnt_q <= sub_cnt_d;
      row_q     <= row_d;
    end
  end

  assign row = row_q;
endmodule

// File: rtl/vga_vtiming.sv
// Vertical timing generator. Counts scanlines from the horizontal generator's
// line strobe and produces vsync, the active window, frame_start, last_line
// and the replicated row index. Defining VGA_VTIMING_FRAME_CNT_EN adds a
// 16-bit frame counter to the interface.
module vga_vtiming
  import vga_timing_pkg::*;
#(
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 29,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT         = 10,
  parameter int SCALE           = 5,
  parameter int ROW_W           = 7,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  vga_vtiming_if.master vif
);
  localparam int V_TOTAL   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int LINE_W    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int ACT_LAST  = V_SYNC + V_BACK + V_ACTIVE - 1;
  localparam int ROWS      = (SCALE > 0) ? (V_ACTIVE / SCALE) : 1;
  localparam logic SYNC_ON = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

  // Illegal parameter sets stop elaboration.
  if (V_SYNC < 1 || V_BACK < 0 || V_ACTIVE < 1 || V_FRONT < 0 || SCALE < 1 ||
      ROW_W < 1 || V_TOTAL < 2 || (V_ACTIVE % SCALE) != 0 ||
      ROW_W < $clog2(ROWS)) begin : g_param_check
    $error("vga_vtiming: illegal parameter set");
  end

  logic              count;
  logic              wrap;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  region_t           region_d;
  logic              vsync_q, vsync_d;
  logic              v_active_q, v_active_d;
  logic              frame_start_q, frame_start_d;
  logic              last_line_q, last_line_d;
  logic [ROW_W-1:0]  row_w;

  assign count = vif.en && vif.line_tick;
  assign wrap  = (line_cnt_q == LINE_W'(V_TOTAL - 1));

  // Next line number and the registered outputs decoded from it, so every
  // output changes on the same edge as the line counter.
  always_comb begin
    line_cnt_d = line_cnt_q;
    if (count) line_cnt_d = wrap ? '0 : line_cnt_q + LINE_W'(1);
    region_d      = line_region(int'(line_cnt_d), V_SYNC, V_BACK, V_ACTIVE);
    vsync_d       = (region_d == SYNC) ? SYNC_ON : ~SYNC_ON;
    v_active_d    = (region_d == ACTIVE);
    last_line_d   = (line_cnt_d == LINE_W'(V_TOTAL - 1));
    // Pulse only for the edge that wraps; it never stretches while en is low.
    frame_start_d = count && wrap;
  end

  // Line counter and output registers; reset lands in line 0 (sync pulse).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_cnt_q    <= '0;
      vsync_q       <= SYNC_ON;
      v_active_q    <= 1'b0;
      frame_start_q <= 1'b0;
      last_line_q   <= 1'b0;
    end else begin
      line_cnt_q    <= line_cnt_d;
      vsync_q       <= vsync_d;
      v_active_q    <= v_active_d;
      frame_start_q <= frame_start_d;
      last_line_q   <= last_line_d;
    end
  end

  // v_active_q describes the line currently ending, which is what the
  // prescaler needs when the tick arrives.
  vga_row_scaler #(
    .SCALE (SCALE),
    .ROW_W (ROW_W)
  ) u_row_scaler (
    .clk         (clk),
    .reset       (reset),
    .tick        (count),
    .active      (v_active_q),
    .last_active (line_cnt_q == LINE_W'(ACT_LAST)),
    .row         (row_w)
  );

  assign vif.vsync       = vsync_q;
  assign vif.v_active    = v_active_q;
  assign vif.row         = row_w;
  assign vif.frame_start = frame_start_q;
  assign vif.last_line   = last_line_q;

`ifdef VGA_VTIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Frame counter steps together with frame_start and wraps naturally.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (count && wrap) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  // Frame counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign vif.frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_vtiming.sv
// Directed bench for vga_vtiming. Two instances share clock, reset and the
// line strobe: dut_a (active-low sync, SCALE=2) and dut_b (active-high sync,
// SCALE=1), both with V_TOTAL=12. Expected values come from hand-written
// per-line tables.
module tb_vga_vtiming;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic line_tick;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_line = 0;
  int exp_frames = 0;

  // Expected row per line number (lines 5..10 are active).
  int row_a_tab [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 0};
  int row_b_tab [12] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 0};

  // Clock / reset
  always #5 clk = ~clk;

  vga_vtiming_if #(.ROW_W(2)) if_a ();
  vga_vtiming_if #(.ROW_W(3)) if_b ();

  assign if_a.en        = en;
  assign if_a.line_tick = line_tick;
  assign if_b.en        = en;
  assign if_b.line_tick = line_tick;

  vga_vtiming #(
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(6), .V_FRONT(1),
    .SCALE(2), .ROW_W(2), .SYNC_ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .vif   (if_a)
  );

  vga_vtiming #(
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(6), .V_FRONT(1),
    .SCALE(1), .ROW_W(3), .SYNC_ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .vif   (if_b)
  );

  // Scoreboard compare
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s line=%0d: got %0d expected %0d", tag, exp_line, got, exp);
  endtask

  // Compare every output of both instances against the tables for exp_line.
  task automatic check_outputs(input logic fs_exp);
    chk("a_vsync",       if_a.vsync,       (exp_line < 2) ? 0 : 1);
    chk("a_v_active",    if_a.v_active,    (exp_line >= 5 && exp_line <= 10) ? 1 : 0);
    chk("a_row",         if_a.row,         row_a_tab[exp_line]);
    chk("a_last_line",   if_a.last_line,   (exp_line == 11) ? 1 : 0);
    chk("a_frame_start", if_a.frame_start, fs_exp);
    chk("b_vsync",       if_b.vsync,       (exp_line < 2) ? 1 : 0);
    chk("b_v_active",    if_b.v_active,    (exp_line >= 5 && exp_line <= 10) ? 1 : 0);
    chk("b_row",         if_b.row,         row_b_tab[exp_line]);
    chk("b_frame_start", if_b.frame_start, fs_exp);
`ifdef VGA_VTIMING_FRAME_CNT_EN
    chk("a_frame_cnt",   if_a.frame_cnt,   exp_frames);
    chk("b_frame_cnt",   if_b.frame_cnt,   exp_frames);
`endif
  endtask

  // Driver: one-cycle line strobe, then three idle cycles (4 clk per line).
  // Called and returning at posedge+1.
  task automatic tick_cycle();
    logic fs;
    fs = 1'b0;
    line_tick = 1'b1;
    @(posedge clk); #1;
    line_tick = 1'b0;
    if (en) begin
      if (exp_line == 11) begin
        exp_line = 0;
        exp_frames++;
        fs = 1'b1;
      end else begin
        exp_line++;
      end
    end
    check_outputs(fs);
    @(posedge clk); #1;
    chk("a_fs_one_clk", if_a.frame_start, 0);
    chk("b_fs_one_clk", if_b.frame_start, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    en        = 1'b1;
    line_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values while reset is held (line 0 sync state).
    check_outputs(1'b0);

    reset = 1'b0;
    // No frame_start after reset release, state stays on line 0.
    repeat (4) begin
      @(posedge clk); #1;
      check_outputs(1'b0);
    end

    // One full frame, ending with the wrap to line 0.
    repeat (12) tick_cycle();

    // Move to line 7 (row 1 on dut_a), then freeze with en low.
    repeat (7) tick_cycle();
    en = 1'b0;
    repeat (5) tick_cycle();
    en = 1'b1;
    tick_cycle();  // line 8
    tick_cycle();  // line 9, prescaler must have held its phase

    // Advance to line 7 of the next frame, then reset asynchronously.
    repeat (10) tick_cycle();
    chk("a_row_pre_reset", if_a.row, 1);
    #3;
    reset = 1'b1;
    #1;
    exp_line   = 0;
    exp_frames = 0;
    check_outputs(1'b0);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    check_outputs(1'b0);

    // First frame after release, then two more.
    repeat (36) tick_cycle();
`ifdef VGA_VTIMING_FRAME_CNT_EN
    chk("a_frame_cnt_3", if_a.frame_cnt, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_vtiming.md
# vga_vtiming

Parametrised vertical timing generator for the VGA output path. It counts scanlines from a one-cycle line strobe supplied by the horizontal timing generator. It produces the vertical sync pulse, the vertical active window, a frame-start strobe, and a replicated row index for the pixel fetch logic. Sync, porch, active height, row replication factor and sync polarity are all parameters, so one block covers every supported mode.

## Interface
- V_SYNC, 2: sync pulse width in lines.
- V_BACK, 29: back porch in lines.
- V_ACTIVE, 480: active lines.
- V_FRONT, 10: front porch in lines.
- SCALE, 5: lines per output row. V_ACTIVE must be a multiple of SCALE.
- ROW_W, 7: width of `row`. Must be at least clog2(V_ACTIVE/SCALE).
- SYNC_ACTIVE_LOW, 1: 1 means vsync is driven low during the pulse.
- clk  in  1: clock.
- reset  in  1: reset, asynchronous, active-high.
- en  in  1: timing enable. When low, all state freezes.
- line_tick  in  1: one-cycle strobe marking the end of each scanline.
- vsync  out  1: vertical sync at the polarity set by SYNC_ACTIVE_LOW.
- v_active  out  1: high during active lines.
- row  out  ROW_W: active row index, 0..V_ACTIVE/SCALE-1.
- frame_start  out  1: one-cycle pulse when the line counter wraps to 0.
- last_line  out  1: high while the line counter equals V_TOTAL-1.
- frame_cnt  out  16: frame counter. Present only when VGA_VTIMING_FRAME_CNT_EN is defined.

## Operation
- V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT.
- line_cnt counts 0..V_TOTAL-1. It advances only when en && line_tick. From V_TOTAL-1 it wraps to 0.
- Line regions:
  - Sync: lines [0, V_SYNC-1].
  - Active: lines [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1].
  - Everything else is porch.
- Row prescaler:
  - sub_cnt runs 0..SCALE-1 and advances on each counted tick that ends an active line.
  - When sub_cnt = SCALE-1 and a tick arrives: sub_cnt returns to 0 and row increments.
  - On the tick that ends the last active line, row and sub_cnt return to 0.
  - row stays 0 outside the active window.
  - With SCALE=1, row equals the active line index.
- frame_start asserts for exactly one clk, on the cycle after the tick that wraps line_cnt to V_TOTAL-1→0. It does not assert after reset.
- en low: line_tick is ignored and all outputs hold. Raising en resumes from the held state; there is no resynchronisation.
- line_tick held high for several cycles with en high: each cycle counts as one tick. The driver is responsible for keeping the strobe to one cycle.
- Parameter violations (non-multiple SCALE, ROW_W too small, any width of 0) are caught by an elaboration-time check and stop elaboration.

## Timing
- All outputs are registered and update on the clk edge following a qualifying tick (latency 1 cycle from the tick).
- Reset values:
  - line_cnt=0, sub_cnt=0, row=0.
  - v_active=0, frame_start=0, last_line=0.
  - vsync at its asserted level: 0 if SYNC_ACTIVE_LOW, else 1.
  - frame_cnt=0.
- Reset asserted mid-frame forces the reset values immediately. After release, counting restarts at line 0, inside the sync pulse.
- line_cnt width is clog2(V_TOTAL). The wrap is by compare, not by overflow.

## Configuration
- VGA_VTIMING_FRAME_CNT_EN defined:
  - A 16-bit frame_cnt port exists.
  - It increments in the same cycle frame_start asserts and wraps 0xFFFF→0.
- VGA_VTIMING_FRAME_CNT_EN not defined: the port and its register are absent. All other behaviour is identical.

## Structure
- Package vga_timing_pkg holds the standard mode constants (sync, back, active, front per mode) and a region enum {SYNC, BACK, ACTIVE, FRONT}. Both timing generators share this package.
- One sub-module, vga_row_scaler, holds sub_cnt/row, with inputs tick, active, and last-active-line.
- The top level holds the line counter, region decode and output registers.

## Test plan
All scenarios use V_SYNC=2, V_BACK=3, V_ACTIVE=6, V_FRONT=1, SCALE=2, ROW_W=2, SYNC_ACTIVE_LOW=1, so V_TOTAL=12, with one line_tick every 4 clk unless stated.
- Reset, then 12 ticks:
  - vsync=0 for lines 0-1, then 1.
  - v_active=1 for lines 5-10.
  - row sequence 0,0,1,1,2,2 across those lines.
  - last_line=1 at line 11.
- Tick at line 11: frame_start pulses for exactly 1 clk as line_cnt becomes 0. No frame_start pulse occurs after reset.
- en=0 with 5 ticks mid-active: line_cnt, row and all outputs unchanged. After en=1, the next tick advances by exactly one line.
- Reset asserted at line 7 (row=1): all outputs return to reset values the same cycle. The first frame after release is complete and correct.
- SYNC_ACTIVE_LOW=0 and SCALE=1: vsync=1 on lines 0-1. row runs 0..5 across the active lines.
- With VGA_VTIMING_FRAME_CNT_EN, 3 full frames: frame_cnt reads 3, incrementing in the same cycle as each frame_start.
